// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - ordered multi-domain reset sequencer with software reset, power-off latch and optional activity blink (RST_SEQ_ACTIVITY_EN)
module rst_seq #(
  parameter int DOMAINCOUNT  = 2,
  parameter int RSTCNTRBITSZ = 16,
  parameter int ACTSRCCOUNT  = 2,
  parameter int ACTCNTRBITSZ = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   pll_locked_i,
  input  logic [DOMAINCOUNT-1:0] hold_i,
  input  logic [1:0]             swrst_i,
  output logic [DOMAINCOUNT-1:0] rst_o,
  output logic                   gsr_o,
  output logic                   pwroff_o,
  input  logic [ACTSRCCOUNT-1:0] actsrc_i,
  output logic                   activity_o
);

  localparam int IDXW = (DOMAINCOUNT > 1) ? $clog2(DOMAINCOUNT) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DOMAINCOUNT - 1);

  typedef enum logic [1:0] {
    WAITPLL = 2'd0,
    COUNT   = 2'd1,
    RUN     = 2'd2,
    PWROFF  = 2'd3
  } state_t;

  state_t                  state;
  logic [RSTCNTRBITSZ-1:0] cntr;
  logic [IDXW-1:0]         idx;

  logic                    hold_any;
  logic [IDXW-1:0]         hold_low;
  logic [DOMAINCOUNT-1:0]  hold_mask;

  // Lowest held domain and the set of domains at or above it that must re-enter reset
  always_comb begin
    hold_any  = 1'b0;
    hold_low  = '0;
    hold_mask = '0;
    for (int k = DOMAINCOUNT - 1; k >= 0; k--) begin
      if (hold_i[k]) begin
        hold_any = 1'b1;
        hold_low = IDXW'(k);
      end
    end
    for (int j = 0; j < DOMAINCOUNT; j++) begin
      if (hold_any && (j >= int'(hold_low))) begin
        hold_mask[j] = 1'b1;
      end
    end
  end

  // Sequencer: commands and lock loss override the normal domain-by-domain release
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state    <= WAITPLL;
      idx      <= '0;
      cntr     <= '1;
      rst_o    <= '1;
      gsr_o    <= 1'b0;
      pwroff_o <= 1'b0;
    end else begin
      gsr_o <= 1'b0;
      if (state == PWROFF) begin
        // Latched off: only rst_n can bring the block back
        state <= PWROFF;
      end else if (swrst_i == 2'b11) begin
        gsr_o <= 1'b1;
        rst_o <= '1;
        idx   <= '0;
        cntr  <= '1;
        state <= WAITPLL;
      end else if (swrst_i == 2'b10) begin
        rst_o <= '1;
        idx   <= '0;
        cntr  <= '1;
        state <= COUNT;
      end else if (swrst_i == 2'b01) begin
        pwroff_o <= 1'b1;
        rst_o    <= '1;
        state    <= PWROFF;
      end else if (!pll_locked_i) begin
        rst_o <= '1;
        state <= WAITPLL;
      end else begin
        case (state)
          WAITPLL: begin
            rst_o <= '1;
            idx   <= '0;
            cntr  <= '1;
            state <= COUNT;
          end
          COUNT: begin
            if (hold_i[idx]) begin
              cntr <= '1;
            end else if (cntr != '0) begin
              cntr <= cntr - RSTCNTRBITSZ'(1);
            end else begin
              rst_o[idx] <= 1'b0;
              cntr       <= '1;
              if (idx == LAST_IDX) begin
                state <= RUN;
              end else begin
                idx <= idx + IDXW'(1);
              end
            end
          end
          RUN: begin
            if (hold_any) begin
              rst_o <= rst_o | hold_mask;
              idx   <= hold_low;
              cntr  <= '1;
              state <= COUNT;
            end
          end
          default: state <= WAITPLL;
        endcase
      end
    end
  end

`ifdef RST_SEQ_ACTIVITY_EN
  logic [ACTCNTRBITSZ-1:0] act_cntr;

  // Activity blink: one-cycle pulse, then ignore sources until the holdoff counter drains
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      act_cntr   <= '0;
      activity_o <= 1'b0;
    end else if (act_cntr != '0) begin
      activity_o <= 1'b0;
      act_cntr   <= act_cntr - ACTCNTRBITSZ'(1);
    end else if (|actsrc_i) begin
      activity_o <= 1'b1;
      act_cntr   <= '1;
    end else begin
      activity_o <= 1'b0;
    end
  end
`else
  logic [31:0] unused_act;
  assign unused_act = ACTCNTRBITSZ ^ 32'(actsrc_i);
  assign activity_o = 1'b0;
`endif

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter DOMAINCOUNT, default 2: number of reset domains, released in index order.
REQ-002 SHALL have parameter RSTCNTRBITSZ, default 16: width of the per-domain release counter.
REQ-003 SHALL have parameter ACTSRCCOUNT, default 2: number of activity sources.
REQ-004 SHALL have parameter ACTCNTRBITSZ, default 7: width of the activity blink counter.
REQ-005 SHALL have port clk_i, input, 1 bit: sole clock.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port pll_locked_i, input, 1 bit: clock source locked.
REQ-008 SHALL have port hold_i, input, DOMAINCOUNT bits: per-domain hold-in-reset request.
REQ-009 SHALL have port swrst_i, input, 2 bits: software reset command {rst1,rst0}.
REQ-010 SHALL have port rst_o, output, DOMAINCOUNT bits: active-high domain resets.
REQ-011 SHALL have port gsr_o, output, 1 bit: one-cycle cold-reset pulse.
REQ-012 SHALL have port pwroff_o, output, 1 bit: latched power-off.
REQ-013 SHALL have port actsrc_i, input, ACTSRCCOUNT bits: activity sources.
REQ-014 SHALL have port activity_o, output, 1 bit: activity blink.

Function
REQ-015 SHALL implement a state machine with states WAITPLL, COUNT, RUN and PWROFF, plus a counter cntr[RSTCNTRBITSZ] and a domain index idx.
REQ-016 WAITPLL: all rst_o SHALL be high; when pll_locked_i=1 the block SHALL go to COUNT with idx=0 and cntr=all-ones.
REQ-017 COUNT, hold_i[idx]=1: cntr SHALL reload to all-ones.
REQ-018 COUNT, hold_i[idx]=0 and cntr!=0: cntr SHALL decrement by one.
REQ-019 COUNT, hold_i[idx]=0 and cntr==0: the block SHALL clear rst_o[idx] and reload cntr; if idx==DOMAINCOUNT-1 it SHALL go to RUN, otherwise idx SHALL increment.
REQ-020 RUN: if any hold_i[k]=1 with k the lowest set index, rst_o[j] SHALL be set for all j>=k, with idx=k, cntr=all-ones, next state COUNT; rst_o[j<k] SHALL be unchanged.
REQ-021 pll_locked_i=0 in WAITPLL/COUNT/RUN: all rst_o SHALL be set and the state SHALL go to WAITPLL.
REQ-022 swrst_i=2'b11 (cold): gsr_o SHALL pulse high for exactly one cycle, all rst_o SHALL be set, next state WAITPLL.
REQ-023 swrst_i=2'b10 (warm): all rst_o SHALL be set, idx=0, cntr=all-ones, next state COUNT.
REQ-024 swrst_i=2'b01 (power-off): pwroff_o=1 and all rst_o SHALL be set, next state PWROFF.
REQ-025 PWROFF SHALL be left only via rst_n=0; all other inputs SHALL be ignored in PWROFF.
REQ-026 Priority, highest first: rst_n, PWROFF state, swrst_i (cold > warm > power-off), pll_locked_i loss, hold_i.
REQ-027 A swrst_i level held across cycles SHALL re-apply its action every cycle; gsr_o SHALL be high every such cycle.
REQ-028 All outputs SHALL be registered; gsr_o SHALL assert on the edge that samples the command.
REQ-029 Activity: when the activity counter !=0, activity_o=0 and the counter SHALL decrement; else if any actsrc_i bit=1, activity_o SHALL be 1 for one cycle and the counter SHALL load all-ones; otherwise activity_o=0.

Reset
REQ-030 rst_n=0 at an edge SHALL set state=WAITPLL, idx=0, cntr=all-ones, rst_o=all-ones, gsr_o=0, pwroff_o=0, activity_o=0 and activity counter=0.
REQ-031 rst_n=0 mid-count or in PWROFF SHALL abort immediately to the reset values, with no partial domain release.

Configuration
REQ-032 With macro RST_SEQ_ACTIVITY_EN defined, the activity counter and REQ-029 SHALL be implemented.
REQ-033 Without RST_SEQ_ACTIVITY_EN, activity_o SHALL be constant 0, actsrc_i SHALL be ignored, and no activity counter SHALL exist.

Verification (DOMAINCOUNT=2, RSTCNTRBITSZ=4, ACTCNTRBITSZ=3)
REQ-034 rst_n low 2 cycles then high, pll_locked_i=1, hold_i=0 -> rst_o[0] falls at edge 17 after release and rst_o[1] at edge 33; gsr_o and pwroff_o stay 0.
REQ-035 hold_i[1]=1 for 10 cycles during domain-1 count -> rst_o[1] release delayed 10 cycles while rst_o[0] stays 0; later, hold_i[1] pulsed in RUN -> rst_o=2'b10, then rst_o[1] clears 16 cycles after the hold drops.
REQ-036 In RUN, swrst_i=2'b11 for 1 cycle -> gsr_o=1 for exactly 1 cycle, rst_o=2'b11, state WAITPLL; with pll_locked_i=0, rst_o stays 2'b11.
REQ-037 In RUN, swrst_i=2'b01 -> pwroff_o=1, rst_o=2'b11; pll_locked_i toggles and swrst_i=2'b11 cause no change; rst_n=0 then clears pwroff_o.
REQ-038 In COUNT, pll_locked_i dropped for 1 cycle -> rst_o=2'b11 and the sequence restarts from domain 0 after relock.
REQ-039 With RST_SEQ_ACTIVITY_EN, actsrc_i=2'b01 held high -> activity_o high 1 cycle every 8 cycles; without the macro -> activity_o constant 0.
